// File: rtl/tone_period_meter.sv
// tone_period_meter: measures clk cycles between tone_in transitions,
// flags when successive measurements agree, and times out on silence.
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-low reset
//   en          - synchronous measurement enable
//   tone_in     - asynchronous square-wave tone
//   half_period - last measured transition-to-transition cycle count
//   valid       - one-cycle pulse when half_period updates
//   locked      - high while consecutive measurements agree within TOL
//   timeout     - one-cycle pulse when no transition for CMAX cycles
module tone_period_meter #(
    parameter int unsigned TOL  = 4,
    parameter logic [15:0] CMAX = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        tone_in,
    output logic [15:0] half_period,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        LOCK
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] prev_q, prev_d;
    logic [15:0] half_period_q, half_period_d;
    logic        valid_q, valid_d;
    logic        locked_q, locked_d;
    logic        timeout_q, timeout_d;

    logic        edge_det;
    logic        sat;
    logic [16:0] diff;
    logic        match;

    // s1/s2 resynchronise the tone; s3 is history for edge detection
    assign s1_d = tone_in;
    assign s2_d = s1_q;
    assign s3_d = s2_q;

    assign edge_det = s2_q ^ s3_q;
    assign sat      = (cnt_q == CMAX);

    // Counter restarts at 1 on an edge so the next edge reads the
    // exact spacing; it parks at CMAX rather than wrapping.
    always_comb begin
        if (edge_det) begin
            cnt_d = 16'd1;
        end else if (sat) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Unsigned magnitude, one bit wider so it never wraps
    always_comb begin
        if (cnt_q >= prev_q) begin
            diff = {1'b0, cnt_q} - {1'b0, prev_q};
        end else begin
            diff = {1'b0, prev_q} - {1'b0, cnt_q};
        end
    end

    assign match = (diff <= 17'(TOL));

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        half_period_d = half_period_q;
        valid_d       = 1'b0;
        timeout_d     = 1'b0;
        locked_d      = locked_q;

        if (!en) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end else if (state_q != IDLE && edge_det) begin
            // Edge wins over saturation: a spacing of exactly CMAX
            // is still a measurement.
            half_period_d = cnt_q;
            prev_d        = cnt_q;
            valid_d       = 1'b1;
            case (state_q)
                ARM: begin
                    state_d = MEAS;
                end
                MEAS, LOCK: begin
                    state_d  = match ? LOCK : MEAS;
                    locked_d = match;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (state_q != IDLE && sat) begin
            state_d   = IDLE;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
        end else if (state_q == IDLE && edge_det) begin
            state_d = ARM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            cnt_q         <= 16'd0;
            prev_q        <= 16'd0;
            half_period_q <= 16'd0;
            valid_q       <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            half_period_q <= half_period_d;
            valid_q       <= valid_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
        end
    end

    assign half_period = half_period_q;
    assign valid       = valid_q;
    assign locked      = locked_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: self-checking bench for tone_period_meter.
// Reference model works from tone change times, not from RTL state.
module tb_tone_period_meter;

    localparam int          TOL  = 4;
    localparam int          CM   = 2047;
    localparam logic [15:0] CMAX = 16'd2047;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        en      = 1'b1;
    logic        tone_in = 1'b0;
    logic [15:0] half_period;
    logic        valid;
    logic        locked;
    logic        timeout;

    tone_period_meter #(
        .TOL (TOL),
        .CMAX(CMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tone_in    (tone_in),
        .half_period(half_period),
        .valid      (valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: cycle numbers at which tone_in was changed (pending)
    int          chg[$];
    int          last_chg = -1000000;
    int          m_phase  = 0;
    int          m_prev   = 0;
    logic        m_valid   = 1'b0;
    logic        m_locked  = 1'b0;
    logic        m_timeout = 1'b0;
    logic [15:0] m_hp      = 16'd0;

    logic [18:0] dut_v;
    assign dut_v = {valid, locked, timeout, half_period};

    function automatic logic [18:0] exp_v();
        return {m_valid, m_locked, m_timeout, m_hp};
    endfunction

    // A tone change driven after posedge p is seen at the outputs
    // after posedge p+3. Spacing is the difference of change times.
    // Phase 0: waiting, 1: one edge seen, 2: measuring.
    function automatic void model_update();
        bit hit;
        int gap;
        int d;
        m_valid   = 1'b0;
        m_timeout = 1'b0;
        if (!rst) return;
        hit = (chg.size() > 0) && (chg[0] == cyc - 3);
        if (hit) void'(chg.pop_front());
        if (!en) begin
            m_phase  = 0;
            m_locked = 1'b0;
        end else if (hit) begin
            gap = cyc - 3 - last_chg;
            if (m_phase == 0) begin
                m_phase = 1;
            end else begin
                m_valid = 1'b1;
                m_hp    = 16'(gap);
                if (m_phase == 2) begin
                    d = gap - m_prev;
                    if (d < 0) d = -d;
                    m_locked = (d <= TOL);
                end
                m_phase = 2;
                m_prev  = gap;
            end
        end else if (m_phase != 0 && cyc == last_chg + 3 + CM) begin
            m_timeout = 1'b1;
            m_phase   = 0;
            m_locked  = 1'b0;
        end
        if (hit) last_chg = cyc - 3;
    endfunction

    task automatic step(input bit tog);
        @(negedge clk);
        cyc++;
        model_update();
        if (tog) begin
            tone_in = ~tone_in;
            if (rst) chg.push_back(cyc);
        end
    endtask

    task automatic hit_reset();
        rst = 1'b0;
        chg.delete();
        m_phase   = 0;
        m_locked  = 1'b0;
        m_valid   = 1'b0;
        m_timeout = 1'b0;
        m_hp      = 16'd0;
    endtask

    // Synchronizer restarts from 0, so a high tone looks like a change
    task automatic release_reset();
        rst = 1'b1;
        if (tone_in) chg.push_back(cyc);
    endtask

    task automatic do_reset();
        en = 1'b1;
        hit_reset();
        step(0);
        step(0);
        release_reset();
    endtask

    task automatic test_reset();
        hit_reset();
        step(0);
        step(0);
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid got=%b want=0", valid);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_locked got=%b want=0", locked);
        end
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_timeout got=%b want=0", timeout);
        end
        n_cmp++;
        if (half_period !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_hp got=%0d want=0", half_period);
        end
        n_cmp++;
        release_reset();
        for (int k = 0; k < 8; k++) begin
            step(0);
            if (dut_v !== exp_v()) begin
                n_fail++;
                $display("FAIL rst_idle cyc=%0d got=%h want=%h",
                         cyc, dut_v, exp_v());
            end
            n_cmp++;
        end
    endtask

    task automatic test_steady();
        int g[$] = '{8, 1281, 1281, 1281, 6};
        do_reset();
        foreach (g[i]) begin
            for (int k = 1; k <= g[i]; k++) begin
                step(k == g[i] && i < 4);
                if (dut_v !== exp_v()) begin
                    n_fail++;
                    $display("FAIL steady cyc=%0d got=%h want=%h",
                             cyc, dut_v, exp_v());
                end
                n_cmp++;
                if (i == 2 && k == 3) begin
                    if (valid !== 1'b1 || half_period !== 16'd1281) begin
                        n_fail++;
                        $display("FAIL steady_first got v=%b hp=%0d want v=1 hp=1281",
                                 valid, half_period);
                    end
                    n_cmp++;
                end
                if (i == 3 && k == 3) begin
                    if (locked !== 1'b1) begin
                        n_fail++;
                        $display("FAIL steady_lock got=%b want=1", locked);
                    end
                    n_cmp++;
                end
            end
        end
        if (locked !== 1'b1 || half_period !== 16'd1281) begin
            n_fail++;
            $display("FAIL steady_hold got l=%b hp=%0d want l=1 hp=1281",
                     locked, half_period);
        end
        n_cmp++;
    endtask

    task automatic test_jitter();
        int g[$] = '{8, 1281, 1290, 1292, 6};
        do_reset();
        foreach (g[i]) begin
            for (int k = 1; k <= g[i]; k++) begin
                step(k == g[i] && i < 4);
                if (dut_v !== exp_v()) begin
                    n_fail++;
                    $display("FAIL jitter cyc=%0d got=%h want=%h",
                             cyc, dut_v, exp_v());
                end
                n_cmp++;
                if (i == 3 && k == 3) begin
                    if (half_period !== 16'd1290 || locked !== 1'b0) begin
                        n_fail++;
                        $display("FAIL jitter_wide got hp=%0d l=%b want hp=1290 l=0",
                                 half_period, locked);
                    end
                    n_cmp++;
                end
                if (i == 4 && k == 3) begin
                    if (half_period !== 16'd1292 || locked !== 1'b1) begin
                        n_fail++;
                        $display("FAIL jitter_close got hp=%0d l=%b want hp=1292 l=1",
                                 half_period, locked);
                    end
                    n_cmp++;
                end
            end
        end
    endtask

    task automatic test_timeout();
        int g[$] = '{8, 300, 300, CM + 8, 8, CM, CM + 1, 6};
        int tc[$];
        do_reset();
        foreach (g[i]) begin
            for (int k = 1; k <= g[i]; k++) begin
                step(k == g[i] && i < 7);
                if (k == g[i] && i < 7) tc.push_back(cyc);
                if (dut_v !== exp_v()) begin
                    n_fail++;
                    $display("FAIL timeout cyc=%0d got=%h want=%h",
                             cyc, dut_v, exp_v());
                end
                n_cmp++;
                if (i == 3 && k == 4) begin
                    if (locked !== 1'b1) begin
                        n_fail++;
                        $display("FAIL to_prelock got=%b want=1", locked);
                    end
                    n_cmp++;
                end
                if (i == 3 && cyc == tc[2] + 3 + CM) begin
                    if (timeout !== 1'b1 || locked !== 1'b0 ||
                        half_period !== 16'd300) begin
                        n_fail++;
                        $display("FAIL to_stop got t=%b l=%b hp=%0d want t=1 l=0 hp=300",
                                 timeout, locked, half_period);
                    end
                    n_cmp++;
                end
                if (i == 6 && cyc == tc[5] + 3) begin
                    if (valid !== 1'b1 || timeout !== 1'b0 ||
                        half_period !== CMAX) begin
                        n_fail++;
                        $display("FAIL to_edge_sat got v=%b t=%b hp=%0d want v=1 t=0 hp=%0d",
                                 valid, timeout, half_period, CM);
                    end
                    n_cmp++;
                end
                if (i == 7 && cyc == tc[5] + 3 + CM) begin
                    if (timeout !== 1'b1 || valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL to_over got t=%b v=%b want t=1 v=0",
                                 timeout, valid);
                    end
                    n_cmp++;
                end
            end
        end
    endtask

    task automatic test_fast();
        do_reset();
        for (int k = 1; k <= 46; k++) begin
            step(k <= 40);
            if (dut_v !== exp_v()) begin
                n_fail++;
                $display("FAIL fast cyc=%0d got=%h want=%h",
                         cyc, dut_v, exp_v());
            end
            n_cmp++;
            if (k == 30) begin
                if (valid !== 1'b1 || locked !== 1'b1 ||
                    half_period !== 16'd1) begin
                    n_fail++;
                    $display("FAIL fast_rate got v=%b l=%b hp=%0d want v=1 l=1 hp=1",
                             valid, locked, half_period);
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_async_reset();
        int g[$] = '{8, 150, 150, 150, 40};
        int h[$] = '{150, 150, 150, 6};
        int nv = 0;
        do_reset();
        foreach (g[i]) begin
            for (int k = 1; k <= g[i]; k++) begin
                step(k == g[i] && i < 4);
                if (dut_v !== exp_v()) begin
                    n_fail++;
                    $display("FAIL arst_pre cyc=%0d got=%h want=%h",
                             cyc, dut_v, exp_v());
                end
                n_cmp++;
            end
        end
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_locked got=%b want=1", locked);
        end
        n_cmp++;
        hit_reset();
        #1;
        if (dut_v !== 19'd0) begin
            n_fail++;
            $display("FAIL arst_now got=%h want=0", dut_v);
        end
        n_cmp++;
        step(0);
        step(1);
        step(0);
        release_reset();
        foreach (h[i]) begin
            for (int k = 1; k <= h[i]; k++) begin
                step(k == h[i] && i < 3);
                if (i == 0 && valid === 1'b1) nv++;
                if (dut_v !== exp_v()) begin
                    n_fail++;
                    $display("FAIL arst_post cyc=%0d got=%h want=%h",
                             cyc, dut_v, exp_v());
                end
                n_cmp++;
            end
        end
        if (nv !== 0) begin
            n_fail++;
            $display("FAIL arst_first_edge got=%0d valids want=0", nv);
        end
        n_cmp++;
    endtask

    task automatic test_enable();
        int g[$] = '{8, 120, 120, 120, 120, 120, 120, 120, 120, 6};
        int lo = 483;
        int n = 0;
        do_reset();
        foreach (g[i]) begin
            for (int k = 1; k <= g[i]; k++) begin
                en = (n < lo || n >= lo + 10);
                step(k == g[i] && i < 9);
                if (dut_v !== exp_v()) begin
                    n_fail++;
                    $display("FAIL enable cyc=%0d got=%h want=%h",
                             cyc, dut_v, exp_v());
                end
                n_cmp++;
                if (n == lo) begin
                    if (locked !== 1'b0) begin
                        n_fail++;
                        $display("FAIL en_drop got=%b want=0", locked);
                    end
                    n_cmp++;
                end
                n++;
            end
        end
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL en_relock got=%b want=1", locked);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        int base;
        int r;
        int g;
        int off;
        int len;
        bit drop;
        do_reset();
        base = $urandom_range(60, 400);
        for (int s = 0; s < 50; s++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                g = CM + $urandom_range(0, 2);
            end else if (r <= 2) begin
                g = $urandom_range(1, 3);
            end else begin
                g = base + $urandom_range(0, 2 * TOL + 3);
            end
            drop = (r == 3 || r == 4);
            off  = $urandom_range(1, g);
            len  = $urandom_range(1, 15);
            for (int k = 1; k <= g; k++) begin
                en = !(drop && k >= off && k < off + len);
                step(k == g);
                if (dut_v !== exp_v()) begin
                    n_fail++;
                    $display("FAIL random cyc=%0d got=%h want=%h",
                             cyc, dut_v, exp_v());
                end
                n_cmp++;
            end
        end
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(0);
            if (dut_v !== exp_v()) begin
                n_fail++;
                $display("FAIL random_tail cyc=%0d got=%h want=%h",
                         cyc, dut_v, exp_v());
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_jitter();
        test_timeout();
        test_fast();
        test_async_reset();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
